// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-sequencing stage: opcodes, timing-state
// encodings and default widths.
package cpu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JMI = 4'h5;
  localparam logic [3:0] OP_JEQ = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LSL = 4'h9;

  // One-hot timing states as seen by the decoder; all-zero means halted
  typedef enum logic [2:0] {
    ST_HALT  = 3'b000,
    ST_EXEC1 = 3'b001,
    ST_EXEC2 = 3'b010,
    ST_FETCH = 3'b100
  } state_t;

  function automatic logic is_defined(input logic [3:0] op);
    return op <= OP_LSL;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Memory bus between the sequencer (master) and the program/data memory (slave).
interface control_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;

  modport master (input mem_rdata, output mem_addr, output mem_we);
  modport slave  (output mem_rdata, input mem_addr, input mem_we);
endinterface

// File: rtl/program_counter.sv
// Program counter with enable, increment and parallel load; load wins over increment.
module program_counter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  // Increment wraps silently at the top of the address space
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (en) begin
      if (load) begin
        pc <= load_val;
      end else if (inc) begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: holds PC/IR, steps FETCH -> EXEC1 [-> EXEC2], drives the
// decoder timing/opcode, memory address and write strobe, resolves jumps, halts on STP.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step_en,
  input  logic                acc_neg,
  input  logic                acc_zero,
  control_sequencer_if.master mem,
  output logic [2:0]          Q,
  output logic [3:0]          C,
  output logic [ADDR_W-1:0]   operand,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic                illegal
);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] ir;
  logic [3:0]        opcode;
  logic              ir_load;
  logic              pc_inc;
  logic              pc_load;

  assign opcode  = ir[DATA_W-1 -: 4];
  assign operand = ir[ADDR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else if (step_en) begin
      state <= state_next;
      if (ir_load) begin
        ir <= mem.mem_rdata;
      end
    end
  end

  // Conditional jumps use the accumulator flags present during EXEC1
  always_comb begin
    state_next = state;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    case (state)
      ST_FETCH: begin
        ir_load    = 1'b1;
        pc_inc     = 1'b1;
        state_next = ST_EXEC1;
      end
      ST_EXEC1: begin
        state_next = ST_FETCH;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: state_next = ST_EXEC2;
          OP_JMP:                 pc_load    = 1'b1;
          OP_JMI:                 pc_load    = acc_neg;
          OP_JEQ:                 pc_load    = acc_zero;
          OP_STP:                 state_next = ST_HALT;
          default:                state_next = ST_FETCH;
        endcase
      end
      ST_EXEC2: state_next = ST_FETCH;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_FETCH;
    endcase
  end

  program_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .en       (step_en),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (operand),
    .pc       (pc)
  );

  // Operand addresses memory only while executing; halt parks the bus on pc
  always_comb begin
    mem.mem_addr = pc;
    if (state == ST_EXEC1 || state == ST_EXEC2) begin
      mem.mem_addr = operand;
    end
  end

  assign mem.mem_we = (state == ST_EXEC1) && (opcode == OP_STA) && step_en;
  assign illegal    = (state == ST_EXEC1) && !is_defined(opcode) && step_en;
  assign halted     = (state == ST_HALT);
  assign Q          = state;
  assign C          = opcode;

endmodule
